// File: rtl/mux_4_way_pkg.sv
// Shared types for the 4-way gathering arbiter.
package mux_4_way_pkg;

    localparam int unsigned CHANNELS = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic {EMPTY, FULL} state_t;

endpackage

// File: rtl/mux_4_way_arbiter_grant.sv
// Combinational 4-way round-robin grant: first requester at or after ptr, wrapping.
module round_robin_grant_4
    import mux_4_way_pkg::*;
(
    input  logic [3:0] req,
    input  sel_t       ptr,
    output logic       grant_valid,
    output sel_t       grant
);

    // Scan farthest offset first so the nearest requester overwrites it.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        for (int k = 3; k >= 0; k--) begin
            sel_t idx;
            idx = ptr + sel_t'(k);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

endmodule

// File: rtl/mux_4_way_arbiter.sv
// Merges four valid/ready channels into one registered output stream, round-robin arbitrated.
module mux_4_way_arbiter
    import mux_4_way_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [1:0]                out_select,
    input  logic                      out_ready
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    sel_t             sel_q, sel_d;
    sel_t             ptr_q, ptr_d;

    logic             grant_valid;
    sel_t             grant;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] words [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_words
        assign words[i] = in_data[i*WIDTH +: WIDTH];
    end

    round_robin_grant_4 u_grant (
        .req         (in_valid),
        .ptr         (ptr_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign can_accept = (state_q == EMPTY) || out_ready;
    // No handshake is offered while reset is held.
    assign xfer       = grant_valid && can_accept && rst_n;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            state_d = FULL;
            data_d  = words[grant];
            sel_d   = grant;
            ptr_d   = grant + sel_t'(1);
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid  = (state_q == FULL);
    assign out_data   = data_q;
    assign out_select = sel_q;

endmodule

// File: tb/tb_mux_4_way_arbiter.sv
// Directed self-checking bench for mux_4_way_arbiter.
module tb_mux_4_way_arbiter;

    localparam int unsigned WIDTH = 16;

    logic              clk;
    logic              rst_n;
    logic [3:0]        in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]        in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [1:0]        out_select;
    logic              out_ready;

    int tests;
    int fails;

    mux_4_way_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_select (out_select),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 4'b1111;
        #2;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_select !== 2'b00) begin
            fails++;
            $display("FAIL reset_state: valid=%b ready=%b sel=%b, want 0 0000 00",
                     out_valid, in_ready, out_select);
        end
        tick();
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        tests++;
        if (in_ready !== 4'b0100) begin
            fails++;
            $display("FAIL reset_release_ready: got %b want 0100", in_ready);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h00C2 || out_select !== 2'b10) begin
            fails++;
            $display("FAIL reset_first_word: valid=%b data=%h sel=%b, want 1 00c2 10",
                     out_valid, out_data, out_select);
        end
        // ptr now 3: with everyone valid, channel 3 must win.
        in_valid = 4'b1111;
        #1;
        tests++;
        if (in_ready !== 4'b1000) begin
            fails++;
            $display("FAIL reset_ptr_after: got %b want 1000", in_ready);
        end
        tick();
        tests++;
        if (out_select !== 2'b11 || out_data !== 16'h00D3) begin
            fails++;
            $display("FAIL reset_ptr_word: sel=%b data=%h, want 11 00d3", out_select, out_data);
        end
    endtask

    task automatic test_fairness();
        logic [1:0]  exp_sel [5];
        logic [15:0] exp_dat [5];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_dat = '{16'h00A0, 16'h00B1, 16'h00C2, 16'h00D3, 16'h00A0};
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_select !== exp_sel[i] || out_data !== exp_dat[i]) begin
                fails++;
                $display("FAIL fairness[%0d]: valid=%b sel=%b data=%h, want 1 %b %h",
                         i, out_valid, out_select, out_data, exp_sel[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 16'h00A0
                || out_select !== 2'b00) begin
                fails++;
                $display("FAIL stall[%0d]: ready=%b valid=%b data=%h sel=%b, want 0000 1 00a0 00",
                         i, in_ready, out_valid, out_data, out_select);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 4'b0010) begin
            fails++;
            $display("FAIL stall_release_ready: got %b want 0010", in_ready);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h00B1 || out_select !== 2'b01) begin
            fails++;
            $display("FAIL stall_next_word: valid=%b data=%h sel=%b, want 1 00b1 01",
                     out_valid, out_data, out_select);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        tick();
        in_valid = 4'b0011;
        #1;
        tests++;
        if (in_ready !== 4'b0001) begin
            fails++;
            $display("FAIL wrap_ready: got %b want 0001", in_ready);
        end
        tick();
        tests++;
        if (out_select !== 2'b00 || out_data !== 16'h00A0) begin
            fails++;
            $display("FAIL wrap_word: sel=%b data=%h, want 00 00a0", out_select, out_data);
        end
        #1;
        tests++;
        if (in_ready !== 4'b0010) begin
            fails++;
            $display("FAIL wrap_ptr: ready=%b want 0010", in_ready);
        end
    endtask

    task automatic test_drain();
        do_reset();
        in_valid  = 4'b1000;
        out_ready = 1'b1;
        tick();
        in_valid = 4'b0000;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h00D3 || out_select !== 2'b11) begin
            fails++;
            $display("FAIL drain_full: valid=%b data=%h sel=%b, want 1 00d3 11",
                     out_valid, out_data, out_select);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b0 || out_data !== 16'h00D3 || out_select !== 2'b11) begin
                fails++;
                $display("FAIL drain_empty[%0d]: valid=%b data=%h sel=%b, want 0 00d3 11",
                         i, out_valid, out_data, out_select);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_select !== 2'b00) begin
            fails++;
            $display("FAIL async_reset: valid=%b data=%h sel=%b, want 0 0000 00",
                     out_valid, out_data, out_select);
        end
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 4'b0010) begin
            fails++;
            $display("FAIL async_release_ready: got %b want 0010", in_ready);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_select !== 2'b01 || out_data !== 16'h00B1) begin
            fails++;
            $display("FAIL async_first_word: valid=%b sel=%b data=%h, want 1 01 00b1",
                     out_valid, out_select, out_data);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        in_data   = {16'h00D3, 16'h00C2, 16'h00B1, 16'h00A0};
        #1;
        test_reset();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_drain();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
